fetch_unit: RTL

- Instruction-fetch stage directly downstream of the program counter.
- Takes the current PC value, issues one request at a time to a variable-latency instruction memory, and loads the returned word into the IF/ID pipeline register.
- Asserts fetchStall_o back to the PC so the PC advances only when the instruction at the current address has been accepted.
- Handles branch/jump redirect flushes and decode-side stalls using a one-entry skid buffer.

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_skid_buf.sv | 63 ++++++
 rtl/fetch_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared definitions for the instruction-fetch stage and its consumers.
//   - fetch_state_e : fetch FSM states (IDLE / WAIT / DRAIN)
//   - FETCH_NOP_INSTR / FETCH_ADDR_W : default bubble word and address width
//   - if_id_t       : IF/ID pipeline record, also consumed by decode
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int          FETCH_ADDR_W    = 32;
    localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // ready to issue a request for the current PC
        WAIT  = 2'd1,   // request outstanding, response still wanted
        DRAIN = 2'd2    // request outstanding, response will be thrown away
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]             instr;
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_ADDR_W-1:0] pc_plus4;
        logic                    valid;
    } if_id_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
//   One-entry holding register for a fetched {instr, pc} pair that arrived
//   while decode was stalled.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   load_i          : capture instr_i/pc_i and mark the entry full
//   clear_i         : empty the entry (drain into IF/ID or redirect flush)
//   instr_i, pc_i   : word and its address to capture
//   full_o          : entry holds a word
//   instr_o, pc_o   : held word and its address
// -----------------------------------------------------------------------------
module fetch_skid_buf
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [31:0]       instr_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              full_o,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o
);

    logic              full_q,  full_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;

    always_comb begin
        full_d  = full_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        // Clear wins: a flush must drop the entry even if a load coincides.
        if (clear_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d  = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q  <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            full_q  <= full_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign full_o  = full_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage between the PC register and IF/ID. Issues one
//   request at a time to a variable-latency instruction memory, loads the
//   returned word into IF/ID, and stalls the PC until that word is accepted.
//   Redirect flushes discard in-flight responses; decode stalls park a
//   returned word in a one-entry skid buffer.
//
// Memory handshake: imemReq_o rises with imemAddr_o already valid and both
//   stay constant until the cycle imemAck_i is high; that cycle completes the
//   transfer (imemData_i valid) and imemReq_o drops on the following edge.
//   Exactly one ack per request, never in the first cycle imemReq_o is high.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   pc_i                  : current PC
//   flush_i               : redirect, high in the cycle the PC loads a target
//   stall_i               : decode hazard, hold IF/ID
//   imemReq_o/imemAddr_o  : memory request and address
//   imemAck_i/imemData_i  : memory response
//   instr_o/pc_o/pcPlus4_o/valid_o : IF/ID register
//   fetchStall_o          : PC hold request
//   dbg_state_o           : current FSM state (fetch_state_e encoding)
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          ADDR_W    = FETCH_ADDR_W,
    parameter logic [31:0] NOP_INSTR = FETCH_NOP_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    input  logic              stall_i,
    output logic              imemReq_o,
    output logic [ADDR_W-1:0] imemAddr_o,
    input  logic              imemAck_i,
    input  logic [31:0]       imemData_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pcPlus4_o,
    output logic              valid_o,
    output logic              fetchStall_o,
    output logic [1:0]        dbg_state_o
);

    fetch_state_e      state_q,     state_d;
    logic              imem_req_q,  imem_req_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       instr_q,     instr_d;
    logic [ADDR_W-1:0] pc_q,        pc_d;
    logic [ADDR_W-1:0] pc_plus4_q,  pc_plus4_d;
    logic              valid_q,     valid_d;

    logic              buf_full;
    logic [31:0]       buf_instr;
    logic [ADDR_W-1:0] buf_pc;
    logic              buf_load;
    logic              buf_clear;

    logic              ack_take;
    logic              accept;

    fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .instr_i (imemData_i),
        .pc_i    (imem_addr_q),
        .full_o  (buf_full),
        .instr_o (buf_instr),
        .pc_o    (buf_pc)
    );

    // A response that is still wanted: WAIT (not DRAIN) and no redirect now.
    assign ack_take = (state_q == WAIT) && imemAck_i && !flush_i;

    // The PC may move when a word enters IF/ID this cycle, or on a redirect.
    assign accept = (ack_take && !stall_i) || (buf_full && !stall_i) || flush_i;

    always_comb begin
        state_d     = state_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;

        unique case (state_q)
            IDLE: begin
                // During a flush pc_i still shows the old PC; the target only
                // appears next cycle, so hold off issuing until then.
                if (!buf_full && !flush_i) begin
                    imem_addr_d = pc_i;
                    imem_req_d  = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (imemAck_i) begin
                    imem_req_d = 1'b0;
                    state_d    = IDLE;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (imemAck_i) begin
                    imem_req_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                imem_req_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;

        if (flush_i) begin
            valid_d   = 1'b0;
            instr_d   = NOP_INSTR;
            buf_clear = 1'b1;
        end else if (stall_i) begin
            // IF/ID holds; a word returning now is parked in the skid buffer.
            buf_load = ack_take;
        end else if (buf_full) begin
            instr_d    = buf_instr;
            pc_d       = buf_pc;
            pc_plus4_d = buf_pc + ADDR_W'(4);
            valid_d    = 1'b1;
            buf_clear  = 1'b1;
        end else if (ack_take) begin
            instr_d    = imemData_i;
            pc_d       = imem_addr_q;
            pc_plus4_d = imem_addr_q + ADDR_W'(4);
            valid_d    = 1'b1;
        end else begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            instr_q     <= NOP_INSTR;
            pc_q        <= '0;
            pc_plus4_q  <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            pc_plus4_q  <= pc_plus4_d;
            valid_q     <= valid_d;
        end
    end

    assign imemReq_o    = imem_req_q;
    assign imemAddr_o   = imem_addr_q;
    assign instr_o      = instr_q;
    assign pc_o         = pc_q;
    assign pcPlus4_o    = pc_plus4_q;
    assign valid_o      = valid_q;
    assign fetchStall_o = reset | !accept;
    assign dbg_state_o  = state_q;

endmodule
